// File: rtl/stack_engine_if.sv
// Request/response bundle between the control FSM (master) and the stack engine (slave).
interface stack_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;
  logic              ovf_flag;
  logic              unf_flag;

  modport master (
    output push_req, pop_req, push_data, err_clr,
    input  busy, done, pop_data, sp, count, full, empty,
           ovf_err, unf_err, ovf_flag, unf_flag
  );

  modport slave (
    input  push_req, pop_req, push_data, err_clr,
    output busy, done, pop_data, sp, count, full, empty,
           ovf_err, unf_err, ovf_flag, unf_flag
  );
endinterface

// File: rtl/stack_engine.sv
// Register-array stack with a descending stack pointer; one PUSH/POP per
// request, three cycles per operation, with sticky overflow/underflow flags.
module stack_engine #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  stack_engine_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PUSH_WR  = 3'd1;
  localparam logic [2:0] PUSH_DEC = 3'd2;
  localparam logic [2:0] POP_INC  = 3'd3;
  localparam logic [2:0] POP_RD   = 3'd4;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] SP_TOP   = ADDR_W'(DEPTH-1);

  logic [2:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] pop_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W:0]   cnt_q;
  logic              done_q, ovf_q, unf_q, ovf_f, unf_f;
  logic              full_c, empty_c, idle_c, ovf_ev, unf_ev;

  // sp sits at DEPTH-1 both when empty and when full; count is the arbiter.
  assign full_c  = (cnt_q == CNT_FULL);
  assign empty_c = (cnt_q == '0);
  assign idle_c  = (state == IDLE);
  assign ovf_ev  = idle_c && bus.push_req && full_c;
  assign unf_ev  = idle_c && !bus.push_req && bus.pop_req && empty_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sp_q   <= SP_TOP;
      cnt_q  <= '0;
      wdata  <= '0;
      pop_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      ovf_f  <= 1'b0;
      unf_f  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= ovf_ev;
      unf_q  <= unf_ev;
      // a fresh error outranks a simultaneous clear
      if (ovf_ev)           ovf_f <= 1'b1;
      else if (bus.err_clr) ovf_f <= 1'b0;
      if (unf_ev)           unf_f <= 1'b1;
      else if (bus.err_clr) unf_f <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.push_req) begin
            if (!full_c) begin
              wdata <= bus.push_data;
              state <= PUSH_WR;
            end
          end else if (bus.pop_req && !empty_c) begin
            state <= POP_INC;
          end
        end
        PUSH_WR:  state <= PUSH_DEC;
        PUSH_DEC: begin
          sp_q   <= sp_q - 1'b1;
          cnt_q  <= cnt_q + 1'b1;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        POP_INC: begin
          sp_q  <= sp_q + 1'b1;
          cnt_q <= cnt_q - 1'b1;
          state <= POP_RD;
        end
        POP_RD: begin
          pop_q  <= mem[sp_q];
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (state == PUSH_WR) mem[sp_q] <= wdata;
  end

  assign bus.busy     = !idle_c;
  assign bus.done     = done_q;
  assign bus.pop_data = pop_q;
  assign bus.sp       = sp_q;
  assign bus.count    = cnt_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;
  assign bus.ovf_flag = ovf_f;
  assign bus.unf_flag = unf_f;
endmodule

// File: tb/tb_stack_engine.sv
// Randomized bench for stack_engine against a queue-based LIFO model.
module tb_stack_engine;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  stack_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] stk[$];
  logic [DATA_W-1:0] pd_m;
  bit                ovf_m, unf_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // next free slot, descending from the top, wrapping mod DEPTH
  function automatic logic [ADDR_W-1:0] sp_m();
    return ADDR_W'(DEPTH - 1 - stk.size());
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"},    32'(bus.count),    32'(stk.size()));
    chk({tag, ".sp"},       32'(bus.sp),       32'(sp_m()));
    chk({tag, ".full"},     32'(bus.full),     32'(stk.size() == DEPTH));
    chk({tag, ".empty"},    32'(bus.empty),    32'(stk.size() == 0));
    chk({tag, ".ovf_flag"}, 32'(bus.ovf_flag), 32'(ovf_m));
    chk({tag, ".unf_flag"}, 32'(bus.unf_flag), 32'(unf_m));
    chk({tag, ".pop_data"}, 32'(bus.pop_data), 32'(pd_m));
  endtask

  task automatic idle_inputs();
    bus.push_req  = 1'b0;
    bus.pop_req   = 1'b0;
    bus.push_data = '0;
    bus.err_clr   = 1'b0;
  endtask

  // Called just after a negedge. noise: 0 quiet, 1 random reqs while busy, 2 pop_req while busy.
  task automatic do_op(input bit p, input bit q, input logic [DATA_W-1:0] d,
                       input bit clr, input int noise);
    int kind;
    bus.push_req  = p;
    bus.pop_req   = q;
    bus.push_data = d;
    bus.err_clr   = clr;
    @(posedge clk);
    if (p)      kind = (stk.size() < DEPTH) ? 1 : 3;
    else if (q) kind = (stk.size() > 0)     ? 2 : 4;
    else        kind = 0;
    if (kind == 3) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
    if (kind == 4) unf_m = 1'b1; else if (clr) unf_m = 1'b0;
    #1;
    idle_inputs();
    if ((kind == 1 || kind == 2) && noise == 1) begin
      bus.push_req  = 1'($urandom_range(0, 1));
      bus.pop_req   = 1'($urandom_range(0, 1));
      bus.push_data = DATA_W'($urandom);
    end else if ((kind == 1 || kind == 2) && noise == 2) begin
      bus.pop_req = 1'b1;
    end
    @(negedge clk);
    if (kind == 1 || kind == 2) begin
      chk("busy1", 32'(bus.busy), 32'd1);
      chk("done1", 32'(bus.done), 32'd0);
      chk("ovf_err1", 32'(bus.ovf_err), 32'd0);
      chk("unf_err1", 32'(bus.unf_err), 32'd0);
      @(negedge clk);
      chk("busy2", 32'(bus.busy), 32'd1);
      chk("done2", 32'(bus.done), 32'd0);
      @(negedge clk);
      if (kind == 1) stk.push_back(d);
      else           pd_m = stk.pop_back();
      chk("busy3", 32'(bus.busy), 32'd0);
      chk("done3", 32'(bus.done), 32'd1);
      check_state(kind == 1 ? "push" : "pop");
      idle_inputs();
    end else begin
      chk("err.busy", 32'(bus.busy), 32'd0);
      chk("err.done", 32'(bus.done), 32'd0);
      chk("ovf_err",  32'(bus.ovf_err), 32'(kind == 3));
      chk("unf_err",  32'(bus.unf_err), 32'(kind == 4));
      check_state("err");
      @(negedge clk);
      chk("ovf_err.pulse", 32'(bus.ovf_err), 32'd0);
      chk("unf_err.pulse", 32'(bus.unf_err), 32'd0);
      chk("err.done2",     32'(bus.done),    32'd0);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    pd_m  = '0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.sp_15", 32'(bus.sp), 32'd15);
    check_state("rst");
    reset = 1'b1;
    @(negedge clk);

    // single push then pop
    do_op(1'b1, 1'b0, 16'h00AA, 1'b0, 0);
    chk("aa.sp", 32'(bus.sp), 32'd14);
    do_op(1'b0, 1'b1, 16'h0000, 1'b0, 0);
    chk("aa.pop", 32'(bus.pop_data), 32'h00AA);

    // fill, overflow, drain in LIFO order
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, DATA_W'(i), 1'b0, 1);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.sp",   32'(bus.sp),   32'd15);
    do_op(1'b1, 1'b0, 16'hDEAD, 1'b0, 0);
    chk("ovf.count", 32'(bus.count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 1'b1, '0, 1'b0, 0);
      chk("lifo", 32'(bus.pop_data), 32'(DEPTH - 1 - i));
    end

    // underflow, then clear
    do_op(1'b0, 1'b1, '0, 1'b0, 0);
    chk("unf.sp", 32'(bus.sp), 32'd15);
    do_op(1'b0, 1'b0, '0, 1'b1, 0);
    chk("clr.unf_flag", 32'(bus.unf_flag), 32'd0);

    // simultaneous push/pop: push wins, pop dropped
    do_op(1'b1, 1'b0, 16'h5555, 1'b0, 0);
    do_op(1'b1, 1'b1, 16'h1234, 1'b0, 2);
    chk("both.count", 32'(bus.count), 32'd2);
    do_op(1'b0, 1'b1, '0, 1'b0, 0);
    chk("both.pop", 32'(bus.pop_data), 32'h1234);
    do_op(1'b0, 1'b1, '0, 1'b0, 0);

    // overflow in the same cycle as err_clr keeps the flag set
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 0);
    do_op(1'b1, 1'b0, 16'hBEEF, 1'b1, 0);
    chk("ovf_vs_clr", 32'(bus.ovf_flag), 32'd1);
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, '0, 1'b0, 0);

    // reset while in PUSH_WR aborts the op
    do_op(1'b1, 1'b0, 16'h0042, 1'b0, 0);
    bus.push_req  = 1'b1;
    bus.push_data = 16'h0777;
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    check_state("abort");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.nodone", 32'(bus.done), 32'd0);
    end
    check_state("abort.after");

    // random traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 300; n++) begin
      int r;
      bit p, q, c;
      r = int'($urandom_range(0, 99));
      if ((n / 40) % 2 == 0) begin p = (r < 60); q = (r >= 50); end
      else                   begin p = (r < 30); q = (r >= 20); end
      c = ($urandom_range(0, 9) == 0);
      do_op(p, q, DATA_W'($urandom), c, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
